decode_issue_stage: RTL and testbench

//   Decode/issue stage between instruction fetch and execute. Accepts 32-bit instructions over a valid/ready

---
 rtl/decode_issue_stage.sv | 155 +++++++++++++++
 tb/tb_decode_issue_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: one decode slot (D) and one issue slot (X) with a per-register
// busy scoreboard for RAW/WAW stalls and same-cycle writeback bypass into the operands.
module decode_issue_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              flush,
    output logic [ADDR_W-1:0] rf_rs,
    output logic [ADDR_W-1:0] rf_rt,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [5:0]        ex_op,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [7:0]        ex_imm,
    output logic              ex_we,
    output logic              illegal
);

    localparam int NREG = 1 << ADDR_W;

    function automatic logic op_legal(input logic [5:0] op);
        return (op <= 6'h07) || (op == 6'h3F);
    endfunction

    function automatic logic op_writes(input logic [5:0] op);
        return op <= 6'h05;
    endfunction

    function automatic logic [DATA_W-1:0] bypass(
        input logic              wv,
        input logic [ADDR_W-1:0] wr,
        input logic [DATA_W-1:0] wd,
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rdata
    );
        return (wv && (wr == src) && (src != '0)) ? wd : rdata;
    endfunction

    logic              run;
    logic              vld_p0;
    logic [31:0]       instr_p0;
    logic              vld_p1;
    logic [5:0]        op_p1;
    logic [ADDR_W-1:0] rd_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic [7:0]        imm_p1;
    logic              we_p1;
    logic [NREG-1:0]   busy;

    logic [5:0]        op_p0;
    logic [ADDR_W-1:0] rs_p0;
    logic [ADDR_W-1:0] rt_p0;
    logic [ADDR_W-1:0] rd_p0;
    logic [7:0]        imm_p0;
    logic              legal_p0;
    logic              we_p0;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   busy_eff;
    logic [NREG-1:0]   busy_nxt;
    logic              hazard;
    logic              advance;
    logic              drop;
    logic              accept;
    logic              unused_bits;

    assign op_p0       = instr_p0[31:26];
    assign rs_p0       = instr_p0[21 +: ADDR_W];
    assign rt_p0       = instr_p0[16 +: ADDR_W];
    assign rd_p0       = instr_p0[11 +: ADDR_W];
    assign imm_p0      = instr_p0[7:0];
    assign unused_bits = ^instr_p0[10:8];

    assign legal_p0 = op_legal(op_p0);
    assign we_p0    = op_writes(op_p0) && (rd_p0 != '0);

    // A writeback landing this edge releases its register for the instruction in D.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_valid) clr_mask[wb_rd] = 1'b1;
        if (advance && we_p0) set_mask[rd_p0] = 1'b1;
        busy_eff    = busy & ~clr_mask;
        busy_nxt    = busy_eff | set_mask;
        busy_nxt[0] = 1'b0;
    end

    assign hazard  = busy_eff[rs_p0] | busy_eff[rt_p0] | (we_p0 & busy_eff[rd_p0]);
    assign advance = vld_p0 & legal_p0 & ~hazard & (~vld_p1 | ex_ready) & ~flush;
    assign drop    = vld_p0 & ~legal_p0;

    assign instr_ready = run & ~flush & (~vld_p0 | advance | drop);
    assign accept      = instr_valid & instr_ready;
    assign illegal     = drop & ~flush;

    assign rf_rs = vld_p0 ? rs_p0 : '0;
    assign rf_rt = vld_p0 ? rt_p0 : '0;

    assign ex_valid = vld_p1;
    assign ex_op    = vld_p1 ? op_p1  : '0;
    assign ex_rd    = vld_p1 ? rd_p1  : '0;
    assign ex_a     = vld_p1 ? a_p1   : '0;
    assign ex_b     = vld_p1 ? b_p1   : '0;
    assign ex_imm   = vld_p1 ? imm_p1 : '0;
    assign ex_we    = vld_p1 & we_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run    <= 1'b0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            busy   <= '0;
        end else begin
            run  <= 1'b1;
            busy <= busy_nxt;
            if (flush)                vld_p0 <= 1'b0;
            else if (accept)          vld_p0 <= 1'b1;
            else if (advance || drop) vld_p0 <= 1'b0;
            if (flush)                vld_p1 <= 1'b0;
            else if (advance)         vld_p1 <= 1'b1;
            else if (ex_ready)        vld_p1 <= 1'b0;
        end
    end

    // Stage p0: raw instruction held in D
    always_ff @(posedge clk) begin
        if (accept) instr_p0 <= instr;
    end

    // Stage p1: decoded fields and bypassed operands held in X
    always_ff @(posedge clk) begin
        if (advance) begin
            op_p1  <= op_p0;
            rd_p1  <= rd_p0;
            imm_p1 <= imm_p0;
            we_p1  <= we_p0;
            a_p1   <= bypass(wb_valid, wb_rd, wb_data, rs_p0, rf_rdata1);
            b_p1   <= bypass(wb_valid, wb_rd, wb_data, rt_p0, rf_rdata2);
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: per-cycle vector table plus flush and
// mid-stream reset sequences, against a simple register-file model (r[n] = 0x10 + n).
module tb_decode_issue_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [31:0] instr;
    logic       flush;
    logic [4:0] rf_rs, rf_rt;
    logic [7:0] rf_rdata1, rf_rdata2;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic [7:0] wb_data;
    logic       ex_valid, ex_ready;
    logic [5:0] ex_op;
    logic [4:0] ex_rd;
    logic [7:0] ex_a, ex_b, ex_imm;
    logic       ex_we, illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rfv(input logic [4:0] a);
        return (a == 5'd0) ? 8'h00 : 8'h10 + {3'b000, a};
    endfunction

    assign rf_rdata1 = rfv(rf_rs);
    assign rf_rdata2 = rfv(rf_rt);

    decode_issue_stage #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .flush(flush), .rf_rs(rf_rs), .rf_rt(rf_rt),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_we(ex_we), .illegal(illegal)
    );

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic        er;
        logic        wv;
        logic [4:0]  wr;
        logic [7:0]  wd;
        logic        x_ir;
        logic        x_ev;
        logic        x_ill;
        logic [4:0]  x_rs;
        logic [5:0]  x_op;
        logic [4:0]  x_rd;
        logic [7:0]  x_a;
        logic [7:0]  x_b;
        logic [7:0]  x_imm;
        logic        x_we;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [7:0] imm);
        return {op, rs, rt, rd, 3'b000, imm};
    endfunction

    task automatic addv(input logic iv, input logic [31:0] ins, input logic er,
                        input logic wv, input logic [4:0] wr, input logic [7:0] wd,
                        input logic ir, input logic ev, input logic ill, input logic [4:0] rs,
                        input logic [5:0] op, input logic [4:0] rd, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] imm, input logic we);
        vec_t t;
        t.iv = iv; t.ins = ins; t.er = er; t.wv = wv; t.wr = wr; t.wd = wd;
        t.x_ir = ir; t.x_ev = ev; t.x_ill = ill; t.x_rs = rs; t.x_op = op;
        t.x_rd = rd; t.x_a = a; t.x_b = b; t.x_imm = imm; t.x_we = we;
        vq.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic iv, input logic [31:0] ins, input logic er,
                       input logic fl, input logic wv, input logic [4:0] wr,
                       input logic [7:0] wd);
        @(negedge clk);
        instr_valid = iv; instr = ins; ex_ready = er; flush = fl;
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        #1;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; flush = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;

        //    iv ins                 er wv wr wd      ir ev il rs  op rd a      b      imm    we
        addv(1, mk(0,2,3,1,0),       1, 0, 0, 0,      1, 0, 0, 0,  0, 0, 0,     0,     0,     0);
        addv(1, mk(1,5,6,4,0),       1, 0, 0, 0,      1, 0, 0, 2,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 0, 0, 0,      1, 1, 0, 5,  0, 1, 8'h12, 8'h13, 0,     1);
        addv(0, 0,                   1, 0, 0, 0,      1, 1, 0, 0,  1, 4, 8'h15, 8'h16, 0,     1);
        addv(0, 0,                   1, 1, 4, 8'hEE,  1, 0, 0, 0,  0, 0, 0,     0,     0,     0);
        addv(1, mk(0,1,3,2,0),       1, 0, 0, 0,      1, 0, 0, 0,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 0, 0, 0,      0, 0, 0, 1,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 0, 0, 0,      0, 0, 0, 1,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 1, 1, 8'h5A,  1, 0, 0, 1,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 0, 0, 0,      1, 1, 0, 0,  0, 2, 8'h5A, 8'h13, 0,     1);
        addv(1, mk(4,0,0,2,8'h33),   1, 0, 0, 0,      1, 0, 0, 0,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 0, 0, 0,      0, 0, 0, 0,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 1, 2, 8'h77,  1, 0, 0, 0,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 0, 0, 0,      1, 1, 0, 0,  4, 2, 0,     0,     8'h33, 1);
        addv(1, mk(0,6,7,5,0),       0, 0, 0, 0,      1, 0, 0, 0,  0, 0, 0,     0,     0,     0);
        addv(1, mk(1,9,10,8,0),      0, 0, 0, 0,      1, 0, 0, 6,  0, 0, 0,     0,     0,     0);
        for (int k = 0; k < 3; k++)
            addv(1, mk(2,12,13,11,0),0, 0, 0, 0,      0, 1, 0, 9,  0, 5, 8'h16, 8'h17, 0,     1);
        addv(1, mk(2,12,13,11,0),    1, 0, 0, 0,      1, 1, 0, 9,  0, 5, 8'h16, 8'h17, 0,     1);
        addv(0, 0,                   1, 0, 0, 0,      1, 1, 0, 12, 1, 8, 8'h19, 8'h1A, 0,     1);
        addv(0, 0,                   1, 0, 0, 0,      1, 1, 0, 0,  2, 11,8'h1C, 8'h1D, 0,     1);
        addv(1, mk(6'h20,1,1,9,0),   1, 0, 0, 0,      1, 0, 0, 0,  0, 0, 0,     0,     0,     0);
        addv(1, mk(0,6,7,3,0),       1, 0, 0, 0,      1, 0, 1, 1,  0, 0, 0,     0,     0,     0);
        addv(1, mk(1,9,9,10,0),      1, 0, 0, 0,      1, 0, 0, 6,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 0, 0, 0,      1, 1, 0, 9,  0, 3, 8'h16, 8'h17, 0,     1);
        addv(0, 0,                   1, 0, 0, 0,      1, 1, 0, 0,  1, 10,8'h19, 8'h19, 0,     1);
        addv(1, mk(0,1,1,0,0),       1, 0, 0, 0,      1, 0, 0, 0,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 0, 0, 0,      1, 0, 0, 1,  0, 0, 0,     0,     0,     0);
        addv(1, mk(0,0,0,4,0),       1, 0, 0, 0,      1, 1, 0, 0,  0, 0, 8'h11, 8'h11, 0,     0);
        addv(0, 0,                   1, 0, 0, 0,      1, 0, 0, 0,  0, 0, 0,     0,     0,     0);
        addv(0, 0,                   1, 0, 0, 0,      1, 1, 0, 0,  0, 4, 0,     0,     0,     1);

        // Power-on reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", instr_ready, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_a", ex_a, 0);
        chk("rst_illegal", illegal, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready_low", instr_ready, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("rel_ready_high", instr_ready, 1);

        // Vector table, one row per cycle
        foreach (vq[i]) begin
            cyc(vq[i].iv, vq[i].ins, vq[i].er, 0, vq[i].wv, vq[i].wr, vq[i].wd);
            chk($sformatf("v%0d_ready", i), instr_ready, vq[i].x_ir);
            chk($sformatf("v%0d_ex_valid", i), ex_valid, vq[i].x_ev);
            chk($sformatf("v%0d_illegal", i), illegal, vq[i].x_ill);
            chk($sformatf("v%0d_rf_rs", i), rf_rs, vq[i].x_rs);
            if (vq[i].x_ev) begin
                chk($sformatf("v%0d_ex_op", i), ex_op, vq[i].x_op);
                chk($sformatf("v%0d_ex_rd", i), ex_rd, vq[i].x_rd);
                chk($sformatf("v%0d_ex_a", i), ex_a, vq[i].x_a);
                chk($sformatf("v%0d_ex_b", i), ex_b, vq[i].x_b);
                chk($sformatf("v%0d_ex_imm", i), ex_imm, vq[i].x_imm);
                chk($sformatf("v%0d_ex_we", i), ex_we, vq[i].x_we);
            end
        end

        // Flush with D and X full and r1 busy
        cyc(1, mk(0,6,7,1,0), 0, 0, 0, 0, 0);
        cyc(1, mk(0,6,7,13,0), 0, 0, 0, 0, 0);
        chk("fl_adv_ready", instr_ready, 1);
        cyc(1, mk(0,6,7,12,0), 0, 1, 0, 0, 0);
        chk("fl_ex_valid_before", ex_valid, 1);
        chk("fl_ex_rd_before", ex_rd, 1);
        chk("fl_ready_during", instr_ready, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("fl_ex_valid_after", ex_valid, 0);
        chk("fl_rf_rs_after", rf_rs, 0);
        chk("fl_illegal_after", illegal, 0);
        chk("fl_ready_after", instr_ready, 1);
        cyc(1, mk(0,1,6,14,0), 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("fl_busy1_stall", instr_ready, 0);
        chk("fl_busy1_noissue", ex_valid, 0);
        cyc(0, 0, 1, 0, 1, 1, 8'h42);
        chk("fl_wb_release", instr_ready, 1);
        cyc(1, mk(0,13,13,15,0), 1, 0, 0, 0, 0);
        chk("fl_issue_valid", ex_valid, 1);
        chk("fl_issue_a", ex_a, 8'h42);
        chk("fl_issue_b", ex_b, 8'h16);
        chk("fl_issue_rd", ex_rd, 14);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("fl_r13_not_busy", instr_ready, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("fl_r13_issue", ex_valid, 1);
        chk("fl_r13_a", ex_a, 8'h1D);

        // Reset asserted mid-stream with D and X full
        cyc(1, mk(0,6,7,1,0), 0, 0, 0, 0, 0);
        cyc(1, mk(0,6,7,9,0), 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; instr_valid = 1'b0;
        #1;
        chk("mr_ex_valid", ex_valid, 0);
        chk("mr_ready", instr_ready, 0);
        chk("mr_rf_rs", rf_rs, 0);
        chk("mr_ex_rd", ex_rd, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_rel_ready_low", instr_ready, 0);
        cyc(1, mk(0,1,2,3,0), 1, 0, 0, 0, 0);
        chk("mr_rel_ready_high", instr_ready, 1);
        chk("mr_no_issue", ex_valid, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("mr_busy_cleared", instr_ready, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("mr_issue_valid", ex_valid, 1);
        chk("mr_issue_a", ex_a, 8'h11);
        chk("mr_issue_b", ex_b, 8'h12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
